// File: rtl/blink_sequencer.sv
// Burst LED sequencer: N blinks of programmable on/off length, optional repeat with a gap.
// Optional feature macro BLINK_SEQ_PWM_EN dims the LED during ON with a 4-bit PWM.
module blink_sequencer #(
    parameter int PRESCALE_DIV = 1000,
    parameter int TICK_W       = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              repeat_en,
    input  logic [CNT_W-1:0]  blink_count,
    input  logic [TICK_W-1:0] on_ticks,
    input  logic [TICK_W-1:0] off_ticks,
    input  logic [TICK_W-1:0] gap_ticks,
    input  logic [3:0]        duty,
    output logic              led,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blinks_left
);
    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t            r_state, w_next;
    logic [PRE_W-1:0]  r_pre;
    logic [TICK_W-1:0] r_phase;
    logic [TICK_W-1:0] r_on, r_off, r_gap;
    logic [CNT_W-1:0]  r_count, r_left;
    logic              r_rep, r_done;
    logic              w_tick, w_last, w_accept;

    function automatic logic [TICK_W-1:0] nz(input logic [TICK_W-1:0] v);
        return (v == '0) ? TICK_W'(1) : v;
    endfunction

    assign w_tick   = (r_pre == PRE_W'(PRESCALE_DIV - 1));
    assign w_last   = w_tick && (r_phase == TICK_W'(1));
    assign w_accept = (r_state == S_IDLE) && start && (blink_count != '0) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_next = S_ON;
                S_ON:   if (w_last)   w_next = S_OFF;
                S_OFF:  if (w_last)   w_next = (r_left > CNT_W'(1)) ? S_ON :
                                               (r_rep ? S_GAP : S_IDLE);
                S_GAP:  if (w_last)   w_next = S_ON;
                default:              w_next = S_IDLE;
            endcase
        end
    end

    // Prescaler free-runs through every active phase so phase lengths stay exact multiples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_phase <= '0;
            r_left  <= '0;
            r_done  <= 1'b0;
            r_on    <= '0;
            r_off   <= '0;
            r_gap   <= '0;
            r_count <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_pre   <= '0;
                r_phase <= '0;
                r_left  <= '0;
            end else begin
                if (r_state == S_IDLE || w_tick) r_pre <= '0;
                else                             r_pre <= r_pre + 1'b1;
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_on    <= nz(on_ticks);
                        r_off   <= nz(off_ticks);
                        r_gap   <= nz(gap_ticks);
                        r_count <= blink_count;
                        r_rep   <= repeat_en;
                        r_left  <= blink_count;
                        r_phase <= nz(on_ticks);
                    end
                    S_ON: if (w_last) r_phase <= r_off;
                          else if (w_tick) r_phase <= r_phase - 1'b1;
                    S_OFF: if (w_last) begin
                        if (r_left > CNT_W'(1)) begin
                            r_left  <= r_left - 1'b1;
                            r_phase <= r_on;
                        end else if (r_rep) begin
                            r_phase <= r_gap;
                            r_done  <= 1'b1;
                        end else begin
                            r_left  <= '0;
                            r_phase <= '0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_tick) r_phase <= r_phase - 1'b1;
                    S_GAP: if (w_last) begin
                        r_phase <= r_on;
                        r_left  <= r_count;
                    end else if (w_tick) r_phase <= r_phase - 1'b1;
                    default: r_phase <= '0;
                endcase
            end
        end
    end

`ifdef BLINK_SEQ_PWM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_pwm <= '0;
        else if (w_accept || w_next == S_IDLE) r_pwm <= '0;
        else                                   r_pwm <= r_pwm + 1'b1;
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = r_done;
        blinks_left = r_left;
        led         = (r_state == S_ON) && (r_pwm < duty);
    end
`else
    logic r_led;
    logic w_unused_duty;

    assign w_unused_duty = ^duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_led <= 1'b0;
        else        r_led <= (w_next == S_ON);
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = r_done;
        blinks_left = r_left;
        led         = r_led;
    end
`endif
endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer (PRESCALE_DIV=4); done pulses are checked by a scoreboard.
module tb_blink_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, repeat_en = 1'b0;
    logic [3:0] blink_count = '0;
    logic [7:0] on_ticks = '0, off_ticks = '0, gap_ticks = '0;
    logic [3:0] duty = '0;
    logic       led, busy, done;
    logic [3:0] blinks_left;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_done_q[$];

    blink_sequencer #(.PRESCALE_DIV(4), .TICK_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .repeat_en(repeat_en),
        .blink_count(blink_count), .on_ticks(on_ticks), .off_ticks(off_ticks),
        .gap_ticks(gap_ticks), .duty(duty), .led(led), .busy(busy), .done(done),
        .blinks_left(blinks_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_checks++;
            if (exp_done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected at cycle %0d: got pulse, expected none", cyc);
            end else begin
                int e;
                e = exp_done_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL done_cycle: got %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick(input logic [3:0] cnt, input logic [7:0] on, input logic [7:0] off,
                        input logic [7:0] gap, input logic rep, output int t);
        @(posedge clk);
        #1;
        blink_count = cnt; on_ticks = on; off_ticks = off; gap_ticks = gap;
        repeat_en = rep; start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2;
        #12;
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_left", int'(blinks_left), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // count=0 is ignored
        kick(4'd0, 8'd1, 8'd1, 8'd1, 1'b0, t);
        chk("cnt0_busy", int'(busy), 0);

        // abort beats start in IDLE
        @(posedge clk);
        #1 blink_count = 4'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", int'(busy), 0);

        // single burst: count=3 on=2 off=1
        kick(4'd3, 8'd2, 8'd1, 8'd0, 1'b0, t);
        exp_done_q.push_back(t + 37);
        chk("sb_busy_T1", int'(busy), 1);
        chk("sb_led_T1", int'(led), 1);
        chk("sb_left_T1", int'(blinks_left), 3);
        wait_cyc(t + 5);
        start = 1'b1; blink_count = 4'd1; on_ticks = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_cyc(t + 8);
        chk("sb_led_T8", int'(led), 1);
        wait_cyc(t + 9);
        chk("sb_led_T9", int'(led), 0);
        wait_cyc(t + 12);
        chk("sb_led_T12", int'(led), 0);
        wait_cyc(t + 13);
        chk("sb_led_T13", int'(led), 1);
        chk("sb_left_T13", int'(blinks_left), 2);
        wait_cyc(t + 25);
        chk("sb_left_T25", int'(blinks_left), 1);
        wait_cyc(t + 36);
        chk("sb_busy_T36", int'(busy), 1);
        wait_cyc(t + 37);
        chk("sb_busy_T37", int'(busy), 0);
        chk("sb_left_T37", int'(blinks_left), 0);

        // repeat: count=2 on=1 off=1 gap=3 -> done every 28 cycles
        kick(4'd2, 8'd1, 8'd1, 8'd3, 1'b1, t);
        exp_done_q.push_back(t + 17);
        exp_done_q.push_back(t + 45);
        exp_done_q.push_back(t + 73);
        chk("rp_left_T1", int'(blinks_left), 2);
        wait_cyc(t + 9);
        chk("rp_left_T9", int'(blinks_left), 1);
        wait_cyc(t + 17);
        chk("rp_led_gap", int'(led), 0);
        chk("rp_busy_gap", int'(busy), 1);
        wait_cyc(t + 29);
        chk("rp_left_reload", int'(blinks_left), 2);
        chk("rp_led_T29", int'(led), 1);
        #0 repeat_en = 1'b0;
        wait_cyc(t + 75);
        chk("rp_busy_T75", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("rp_abort_busy", int'(busy), 0);
        chk("rp_abort_left", int'(blinks_left), 0);

        // abort in 2nd OFF, restart one cycle later
        kick(4'd3, 8'd2, 8'd1, 8'd0, 1'b0, t);
        wait_cyc(t + 22);
        chk("ab_led_off2", int'(led), 0);
        chk("ab_left_off2", int'(blinks_left), 2);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_led", int'(led), 0);
        chk("ab_left", int'(blinks_left), 0);
        blink_count = 4'd1; on_ticks = 8'd0; off_ticks = 8'd0; start = 1'b1;
        t2 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        exp_done_q.push_back(t2 + 9);
        chk("re_busy", int'(busy), 1);
        chk("re_led", int'(led), 1);
        wait_cyc(t2 + 4);
        chk("on0_led_T4", int'(led), 1);
        wait_cyc(t2 + 5);
        chk("on0_led_T5", int'(led), 0);
        wait_cyc(t2 + 12);
        chk("done_queue_empty", exp_done_q.size(), 0);

        // async reset in the middle of ON
        kick(4'd2, 8'd2, 8'd1, 8'd0, 1'b0, t);
        wait_cyc(t + 3);
        chk("ar_led_before", int'(led), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_led", int'(led), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        chk("ar_left", int'(blinks_left), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_stays_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
